// File: rtl/fir_frame_buffer.sv
// Ping-pong frame buffer between the FIR low-pass stage and the FFT stage.
// Two banks alternate: one fills from the FIR stream while the other is
// presented in parallel to the FFT through a valid/ready handshake. If both
// banks are full, incoming samples are dropped and counted.
module fir_frame_buffer #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned DW        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fir_valid,
  input  logic [DW-1:0]           fir_d,
  input  logic                    frame_ready,
  output logic                    frame_valid,
  output logic [DW*FRAME_LEN-1:0] frame_data,
  output logic [7:0]              frame_seq,
  output logic                    overflow,
  output logic [15:0]             drop_cnt
);

  localparam int unsigned CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {StEmpty, StFilling, StFull} bank_st_e;

  bank_st_e      st_q [2];
  bank_st_e      st_d [2];
  logic [DW-1:0] mem_q [2][FRAME_LEN];

  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [7:0]    seq_q, seq_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   drop_q, drop_d;

  logic wr_full;
  logic wr_en;
  logic drop;
  logic rel;

  // Write/drop/release decode from current register state only.
  always_comb begin
    wr_full     = (st_q[wr_bank_q] == StFull);
    wr_en       = fir_valid && !wr_full;
    drop        = fir_valid && wr_full;
    frame_valid = (st_q[rd_bank_q] == StFull);
    rel         = frame_valid && frame_ready;
  end

  // Next-state for bank states, pointers, sequence and drop accounting.
  always_comb begin
    st_d[0]   = st_q[0];
    st_d[1]   = st_q[1];
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    seq_d     = seq_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q;

    // A write only targets a non-full bank and a release only a full one,
    // so the two never collide on the same bank.
    if (wr_en) begin
      if (wr_cnt_q == LastIdx) begin
        st_d[wr_bank_q] = StFull;
        wr_cnt_d        = '0;
        wr_bank_d       = ~wr_bank_q;
      end else begin
        st_d[wr_bank_q] = StFilling;
        wr_cnt_d        = wr_cnt_q + 1'b1;
      end
    end

    if (rel) begin
      st_d[rd_bank_q] = StEmpty;
      rd_bank_d       = ~rd_bank_q;
      seq_d           = seq_q + 8'd1;
    end

    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
  end

  // State registers and bank storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q[0]   <= StEmpty;
      st_q[1]   <= StEmpty;
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      seq_q     <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned n = 0; n < FRAME_LEN; n++) begin
          mem_q[b][n] <= '0;
        end
      end
    end else begin
      st_q[0]   <= st_d[0];
      st_q[1]   <= st_d[1];
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      seq_q     <= seq_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
      if (wr_en) mem_q[wr_bank_q][wr_cnt_q] <= fir_d;
    end
  end

  // Present the read bank, forced to zero when no frame is valid.
  always_comb begin
    frame_data = '0;
    if (frame_valid) begin
      for (int unsigned n = 0; n < FRAME_LEN; n++) begin
        frame_data[n*DW +: DW] = mem_q[rd_bank_q][n];
      end
    end
  end

  assign frame_seq = seq_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

endmodule

// File: doc/fir_frame_buffer.md
# fir_frame_buffer

Ping-pong frame buffer that sits directly downstream of the FIR low-pass stage in the frequency analysis system. It collects consecutive filtered samples (`fir_valid`/`fir_d`) into frames of FRAME_LEN samples and presents each completed frame in parallel to the FFT stage through a valid/ready handshake. While the FFT is busy with one bank, the other bank keeps filling. Overflow is detected and reported when the FFT cannot keep up.

## Interface
- FRAME_LEN, 16, samples per frame; must be a power of 2, ≥ 2.
- DW, 16, sample width; matches FIR output.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- fir_valid  in  1  sample strobe; `fir_d` is captured on every edge where it is high.
- fir_d  in  DW  filtered sample.
- frame_ready  in  1  FFT stage accepts the presented frame.
- frame_valid  out  1  a full frame is presented.
- frame_data  out  DW*FRAME_LEN  frame contents.
  - Sample n (n-th written, n=0 first) is at bits [n*DW +: DW].
  - All zeros when `frame_valid`=0.
- frame_seq  out  8  sequence number of the presented frame; increments per accepted frame and wraps 255→0.
- overflow  out  1  sticky; set when any sample is dropped; cleared only by `rst`.
- drop_cnt  out  16  dropped-sample count; saturates at 0xFFFF.

## Operation
- Two banks, each FRAME_LEN×DW registers. Each bank has a state: EMPTY, FILLING or FULL.
- Write side: `wr_bank` (1 bit) and `wr_cnt` (log2 FRAME_LEN bits).
  - If `fir_valid`=1 and `wr_bank` is EMPTY or FILLING: write `fir_d` to `bank[wr_bank][wr_cnt]` and increment `wr_cnt`. An EMPTY bank becomes FILLING.
  - When `wr_cnt`=FRAME_LEN-1 and a write occurs: the bank becomes FULL, `wr_cnt` wraps to 0, and `wr_bank` toggles.
  - If `fir_valid`=1 and `wr_bank` is FULL: the sample is dropped, `overflow`←1, and `drop_cnt`+1 (saturating). `wr_cnt` stays 0, so a frame never spans a drop gap.
  - If `fir_valid`=0: no change. A partial frame is held indefinitely and there is no timeout.
- Read side: `rd_bank` (1 bit).
  - `frame_valid` = (`bank[rd_bank]` state is FULL).
  - Handshake fires when `frame_valid` and `frame_ready` are both 1 on an edge. On that edge: `rd_bank` becomes EMPTY, `rd_bank` toggles, and `frame_seq` increments.
  - While `frame_valid`=1 and `frame_ready`=0, `frame_data` and `frame_seq` are held stable.
- Simultaneous events:
  - Release and write target different banks in the same cycle: both take effect.
  - Release of the bank that `wr_bank` waits on: the release takes effect after the edge. A sample arriving on that same edge is still dropped.
- Reset: on the edge where `rst`=1, regardless of state (mid-fill or mid-handshake):
  - All bank registers are cleared to 0 and all banks go EMPTY.
  - `wr_cnt`=0, `wr_bank`=0, `rd_bank`=0.
  - `frame_seq`=0, `overflow`=0, `drop_cnt`=0.
  - The `fir_valid` input is ignored in that cycle.

## Timing
- Reset values: `frame_valid`=0, `frame_data`=0, `frame_seq`=0, `overflow`=0, `drop_cnt`=0.
- Fill latency: if the FRAME_LEN-th sample is captured at edge k, `frame_valid`=1 from edge k (visible in cycle k+1).
- Release: a handshake at edge h sets `frame_valid`=0 after h, unless the other bank is already FULL. In that case `frame_valid` stays 1 and the next frame is presented immediately, with `frame_seq`+1.
- Throughput: with `frame_ready` tied high, a continuous stream at 1 sample/cycle is sustained with zero drops. Each frame is presented for exactly 1 cycle.
- `overflow` and `drop_cnt` update on the edge where the sample is dropped.
- `frame_data` is a mux of `rd_bank` registers gated by `frame_valid`. It is register-driven, with no combinational path from `fir_d` or `fir_valid`.

## Test plan
- **Reset:** drive `rst` for 3 cycles with random inputs -> all outputs 0 and `frame_valid` never asserts.
- **Single frame:** `fir_valid`=1, `fir_d`=1..16, `frame_ready`=1 -> `frame_valid`=1 for one cycle, exactly one cycle after the 16th sample edge. `frame_data[15:0]`=1, `frame_data[255:240]`=16, `frame_seq`=0.
- **Back-to-back frames:** stream 32 samples 1..32 with `frame_ready`=1 -> two frames, 1..16 with seq 0 and 17..32 with seq 1, in consecutive 16-cycle slots. `overflow`=0.
- **Overflow:**
  - Stimulus: `frame_ready`=0 while streaming samples 1..48.
  - Expected: after sample 32 both banks are FULL, samples 33..48 are dropped, `overflow`=1, `drop_cnt`=16.
  - Then raise `frame_ready` -> frame 1..16 (seq 0) on the first cycle and frame 17..32 (seq 1) on the next.
  - Then stream sample 49 -> it lands at position 0 of the freed bank.
- **Gapped input:** 8 samples (1..8), `fir_valid` low for 5 cycles, then 8 samples (9..16) -> one frame containing 1..16 in order. No drop.
- **Reset mid-fill:** 10 samples, then `rst` for 1 cycle, then 16 samples 100..115 -> a single frame 100..115 with seq 0, and no trace of the earlier data.
